// File: rtl/router_pkg.sv
// Shared types and header field positions for the 1x3 router ingress.
// Imported by the ingress controller and its per-port watchdog.
package router_pkg;

  localparam int NUM_PORTS    = 3;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE,
    LFD,
    PAYLOAD,
    PARITY,
    CHECK,
    DROP
  } state_e;

endpackage

// File: rtl/router_port_wdog.sv
// Per-port stale-FIFO watchdog: counts unread non-empty cycles and
// emits a one-cycle soft-reset pulse when the count reaches TIMEOUT-1.
module router_port_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld_i,
  input  logic rd_i,
  output logic sr_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            sr_q, sr_d;

  always_comb begin
    cnt_d = '0;
    sr_d  = 1'b0;
    if (vld_i && !rd_i) begin
      if (cnt_q == LAST) begin
        sr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign sr_o = sr_q;

endmodule

// File: rtl/router_ingress_ctrl.sv
// Router ingress: header decode, FIFO steering, full back-pressure, parity.
// Define ROUTER_TIMEOUT_EN to add per-port stale-FIFO soft reset.
module router_ingress_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_en,
  output logic                 busy,
  output logic                 lfd_state,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [7:0]           data_to_fifo,
  output logic                 err,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d;
  logic [7:0] par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       wpend_q, wpend_d;
  logic       err_q, err_d;

  logic       in_pkt, stall, abort, accept;
  logic [5:0] hdr_len;
  logic [1:0] hdr_addr;

  assign hdr_len  = data_in[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_addr = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];

  assign in_pkt = state_q inside {LFD, PAYLOAD, PARITY, CHECK};
  assign stall  = wpend_q & fifo_full[addr_q];
  assign abort  = in_pkt & soft_reset[addr_q];
  assign busy   = (state_q == LFD) | (state_q == CHECK) | stall | abort;
  assign accept = pkt_valid & ~busy;

  assign lfd_state    = (state_q == LFD);
  assign data_to_fifo = data_q;
  assign err          = err_q;
  assign vld_out      = ~fifo_empty;
  assign write_enb    = (wpend_q & ~fifo_full[addr_q] & ~abort)
                      ? (NUM_PORTS'(1) << addr_q) : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    par_d   = par_q;
    err_d   = err_q;
    data_d  = accept ? data_in : data_q;
    wpend_d = stall;
    if (abort) begin
      // len_q already counts the bytes left before the parity byte
      wpend_d = 1'b0;
      state_d = (state_q == CHECK) ? DECODE : DROP;
    end else begin
      unique case (state_q)
        DECODE: if (accept) begin
          len_d = hdr_len;
          if (hdr_addr == ADDR_INVALID) begin
            state_d = DROP;
          end else begin
            addr_d  = hdr_addr;
            par_d   = data_in;
            err_d   = 1'b0;
            state_d = LFD;
          end
        end
        LFD: begin
          wpend_d = 1'b1;
          state_d = (len_q == '0) ? PARITY : PAYLOAD;
        end
        PAYLOAD: if (accept) begin
          wpend_d = 1'b1;
          par_d   = par_q ^ data_in;
          len_d   = len_q - 6'd1;
          if (len_q == 6'd1) state_d = PARITY;
        end
        PARITY: if (accept) begin
          wpend_d = 1'b1;
          par_d   = par_q ^ data_in;
          state_d = CHECK;
        end
        CHECK: if (!stall) begin
          err_d   = |par_q;
          state_d = DECODE;
        end
        DROP: if (accept) begin
          if (len_q == '0) state_d = DECODE;
          else len_d = len_q - 6'd1;
        end
        default: state_d = DECODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DECODE;
      addr_q  <= '0;
      len_q   <= '0;
      par_q   <= '0;
      data_q  <= '0;
      wpend_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      par_q   <= par_d;
      data_q  <= data_d;
      wpend_q <= wpend_d;
      err_q   <= err_d;
    end
  end

`ifdef ROUTER_TIMEOUT_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wdog
    router_port_wdog #(
      .TIMEOUT(TIMEOUT),
      .TO_W   (TO_W)
    ) u_wdog (
      .clk   (clk),
      .resetn(resetn),
      .vld_i (vld_out[i]),
      .rd_i  (read_en[i]),
      .sr_o  (soft_reset[i])
    );
  end
`else
  localparam int unused_cfg = TIMEOUT + TO_W;
  logic unused_rd;
  assign unused_rd  = ^read_en;
  assign soft_reset = '0;
`endif

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Scoreboard bench for router_ingress_ctrl: expected FIFO writes are
// queued as bytes are driven and matched against observed write_enb.
module tb_router_ingress_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] fifo_full = '0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] read_en = '0;
  logic       busy, lfd_state, err;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic [7:0] data_to_fifo;

  typedef struct packed {
    logic [31:0] c;
    logic [2:0]  we;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  int         obs_rd = 0;
  int         pass = 0;
  int         total = 0;
  int         hang = 0;
  int         waits = 0;
  int         cnt = 0;
  int         lfd_c = -1;
  logic [7:0] pl[0:63];

  always #5 clk = ~clk;

  router_ingress_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .read_en     (read_en),
    .busy        (busy),
    .lfd_state   (lfd_state),
    .write_enb   (write_enb),
    .data_to_fifo(data_to_fifo),
    .err         (err),
    .vld_out     (vld_out),
    .soft_reset  (soft_reset)
  );

  always @(posedge clk) cnt <= cnt + 1;

  always @(negedge clk) begin
    if (write_enb != 3'b000)
      obs_q.push_back(wr_t'({32'(cnt), write_enb, data_to_fifo}));
    if (lfd_state) lfd_c <= cnt;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    pkt_valid = 1'b1;
    data_in   = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
      if (!ok) waits++;
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    if (!ok) hang++;
  endtask

  task automatic push_exp(input logic [2:0] oh, input logic [7:0] d);
    if (oh != 3'b000) exp_q.push_back(wr_t'({32'd0, oh, d}));
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] flip,
                          input int gap);
    logic [7:0] p;
    logic [2:0] oh;
    int         n;
    n  = int'(hdr[7:2]);
    p  = hdr;
    oh = (hdr[1:0] == 2'd3) ? 3'b000 : (3'b001 << hdr[1:0]);
    push_exp(oh, hdr);
    send_byte(hdr);
    for (int i = 0; i < n; i++) begin
      cyc(gap);
      p = p ^ pl[i];
      push_exp(oh, pl[i]);
      send_byte(pl[i]);
    end
    cyc(gap);
    p = p ^ flip;
    push_exp(oh, p);
    send_byte(p);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, lfd_state, err} !== 3'b000)
      $display("FAIL rst_flags got %b want 000", {busy, lfd_state, err});
    else pass++;
    total++;
    if ({write_enb, soft_reset, vld_out} !== 9'd0)
      $display("FAIL rst_vec got %b/%b/%b want 0",
               write_enb, soft_reset, vld_out);
    else pass++;
    total++;
    if (data_to_fifo !== 8'h00)
      $display("FAIL rst_data got %h want 00", data_to_fifo);
    else pass++;
    @(posedge clk);
    #1;
    fifo_empty = 3'b101;
    @(negedge clk);
    total++;
    if (vld_out !== 3'b010)
      $display("FAIL rst_vld got %b want 010", vld_out);
    else pass++;
    @(posedge clk);
    #1;
    fifo_empty = 3'b111;
    resetn     = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic;
    wr_t e, o;
    int  b;
    b     = obs_rd;
    pl[0] = 8'hA5;
    pl[1] = 8'h3C;
    send_pkt(8'h09, 8'h00, 0);
    cyc(4);
    total++;
    if (obs_q.size() - b != 4) begin
      $display("FAIL basic_cnt got %0d want 4", obs_q.size() - b);
    end else begin
      pass++;
      total++;
      if (obs_q[b+3].c - obs_q[b].c !== 32'd3)
        $display("FAIL basic_consec got %0d want 3",
                 obs_q[b+3].c - obs_q[b].c);
      else pass++;
      total++;
      if (lfd_c !== int'(obs_q[b].c) - 1)
        $display("FAIL basic_lfd got %0d want %0d",
                 lfd_c, int'(obs_q[b].c) - 1);
      else pass++;
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      total++;
      if (o.we !== e.we || o.d !== e.d)
        $display("FAIL basic_wr got %b/%h want %b/%h", o.we, o.d, e.we, e.d);
      else pass++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    total++;
    if (err !== 1'b0 || hang != 0)
      $display("FAIL basic_err got err=%b hang=%0d want 0/0", err, hang);
    else pass++;
  endtask

  task automatic test_parity_err;
    wr_t e, o;
    pl[0] = 8'hA5;
    pl[1] = 8'h3C;
    send_pkt(8'h09, 8'h01, 0);
    cyc(4);
    total++;
    if (obs_q.size() - obs_rd != exp_q.size())
      $display("FAIL perr_cnt got %0d want %0d",
               obs_q.size() - obs_rd, exp_q.size());
    else pass++;
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      total++;
      if (o.we !== e.we || o.d !== e.d)
        $display("FAIL perr_wr got %b/%h want %b/%h", o.we, o.d, e.we, e.d);
      else pass++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    total++;
    if (err !== 1'b1)
      $display("FAIL perr_err got %b want 1", err);
    else pass++;
  endtask

  task automatic test_drop;
    wr_t e, o;
    int  b, w0;
    b  = obs_q.size();
    w0 = waits;
    send_pkt(8'h03, 8'h00, 0);
    cyc(2);
    total++;
    if (obs_q.size() != b || waits != w0)
      $display("FAIL drop_quiet got writes=%0d waits=%0d want 0/0",
               obs_q.size() - b, waits - w0);
    else pass++;
    total++;
    if (err !== 1'b1)
      $display("FAIL drop_err got %b want 1", err);
    else pass++;
    push_exp(3'b100, 8'h06);
    send_byte(8'h06);
    @(negedge clk);
    total++;
    if (lfd_state !== 1'b1 || err !== 1'b0)
      $display("FAIL drop_hdr got lfd=%b err=%b want 1/0", lfd_state, err);
    else pass++;
    @(posedge clk);
    #1;
    push_exp(3'b100, 8'hC3);
    send_byte(8'hC3);
    push_exp(3'b100, 8'hC5);
    send_byte(8'hC5);
    cyc(4);
    total++;
    if (obs_q.size() - obs_rd != exp_q.size())
      $display("FAIL drop_cnt got %0d want %0d",
               obs_q.size() - obs_rd, exp_q.size());
    else pass++;
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      total++;
      if (o.we !== e.we || o.d !== e.d)
        $display("FAIL drop_wr got %b/%h want %b/%h", o.we, o.d, e.we, e.d);
      else pass++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic test_full;
    wr_t e, o;
    fifo_full = 3'b001;
    push_exp(3'b001, 8'h04);
    send_byte(8'h04);
    cyc(3);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || write_enb !== 3'b000)
      $display("FAIL full_hold got busy=%b we=%b want 1/000", busy, write_enb);
    else pass++;
    total++;
    if (data_to_fifo !== 8'h04)
      $display("FAIL full_data got %h want 04", data_to_fifo);
    else pass++;
    @(posedge clk);
    #1;
    read_en[0] = 1'b1;
    @(negedge clk);
    total++;
    if (write_enb !== 3'b000)
      $display("FAIL full_rd got %b want 000", write_enb);
    else pass++;
    @(posedge clk);
    #1;
    read_en   = '0;
    fifo_full = '0;
    @(negedge clk);
    total++;
    if (write_enb !== 3'b001 || data_to_fifo !== 8'h04)
      $display("FAIL full_fire got %b/%h want 001/04", write_enb, data_to_fifo);
    else pass++;
    @(posedge clk);
    #1;
    push_exp(3'b001, 8'h77);
    send_byte(8'h77);
    push_exp(3'b001, 8'h73);
    send_byte(8'h73);
    cyc(4);
    total++;
    if (obs_q.size() - obs_rd != exp_q.size())
      $display("FAIL full_cnt got %0d want %0d",
               obs_q.size() - obs_rd, exp_q.size());
    else pass++;
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      total++;
      if (o.we !== e.we || o.d !== e.d)
        $display("FAIL full_wr got %b/%h want %b/%h", o.we, o.d, e.we, e.d);
      else pass++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic test_back_to_back;
    wr_t e, o;
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
    send_pkt(8'h02, 8'h00, 0);
    send_pkt(8'hFC, 8'h00, 0);
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
    send_pkt(8'h0D, 8'h00, 2);
    cyc(4);
    total++;
    if (obs_q.size() - obs_rd != 72 || exp_q.size() != 72)
      $display("FAIL b2b_cnt got %0d want 72", obs_q.size() - obs_rd);
    else pass++;
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      total++;
      if (o.we !== e.we || o.d !== e.d)
        $display("FAIL b2b_wr got %b/%h want %b/%h", o.we, o.d, e.we, e.d);
      else pass++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    total++;
    if (err !== 1'b0 || hang != 0)
      $display("FAIL b2b_err got err=%b hang=%0d want 0/0", err, hang);
    else pass++;
  endtask

  task automatic test_timeout;
    int first = -1;
    int n = 0;
    int other = 0;
    fifo_empty = 3'b011;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (soft_reset[2]) begin
        n++;
        if (first < 0) first = i;
      end
      if (soft_reset[1:0] != 2'b00) other++;
    end
    @(posedge clk);
    #1;
    fifo_empty = 3'b111;
    cyc(1);
    fifo_empty = 3'b011;
`ifdef ROUTER_TIMEOUT_EN
    total++;
    if (first != 31 || n != 1 || other != 0)
      $display("FAIL to_pulse got first=%0d n=%0d other=%0d want 31/1/0",
               first, n, other);
    else pass++;
`else
    total++;
    if (n != 0 || other != 0)
      $display("FAIL to_off got n=%0d other=%0d want 0/0", n, other);
    else pass++;
`endif
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      read_en[2] = (i == 29);
      if (soft_reset[2]) n++;
    end
    read_en = '0;
    @(posedge clk);
    #1;
    fifo_empty = 3'b111;
    total++;
    if (n != 0)
      $display("FAIL to_read got %0d pulses want 0", n);
    else pass++;
    cyc(2);
  endtask

  task automatic test_reset_mid;
    wr_t e, o;
    push_exp(3'b010, 8'h15);
    send_byte(8'h15);
    push_exp(3'b010, 8'h11);
    send_byte(8'h11);
    push_exp(3'b010, 8'h22);
    send_byte(8'h22);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, lfd_state, err, write_enb, soft_reset} !== 9'd0)
      $display("FAIL rmid_ctl got %b want 0",
               {busy, lfd_state, err, write_enb, soft_reset});
    else pass++;
    total++;
    if (data_to_fifo !== 8'h00)
      $display("FAIL rmid_data got %h want 00", data_to_fifo);
    else pass++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(1);
    pl[0] = 8'h5E;
    send_pkt(8'h05, 8'h00, 0);
    cyc(4);
    total++;
    if (obs_q.size() - obs_rd != 6 || exp_q.size() != 6)
      $display("FAIL rmid_cnt got %0d want 6", obs_q.size() - obs_rd);
    else pass++;
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      total++;
      if (o.we !== e.we || o.d !== e.d)
        $display("FAIL rmid_wr got %b/%h want %b/%h", o.we, o.d, e.we, e.d);
      else pass++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    total++;
    if (err !== 1'b0 || hang != 0)
      $display("FAIL rmid_err got err=%b hang=%0d want 0/0", err, hang);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_drop();
    test_full();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
